mips: RTL and testbench

Multicycle 8-bit MIPS-subset processor core: fetches 32-bit instructions one byte at a time from an external byte-addressed, combinational-read memory and executes them over 5–8 cycles each. It sits between the system clock/reset and the external code/data memory. It is the only master on that memory.

---
 rtl/mips_pkg.sv | 84 ++++++++
 rtl/mips_controller.sv | 90 +++++++++
 rtl/mips.sv | 137 +++++++++++++
 tb/tb_mips.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle 8-bit MIPS-subset core: opcodes, functs,
// ALU control, FSM states and the control-word bundle driven by the controller.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_ZERO
   } alu_ctrl_e;

   typedef enum logic [3:0] {
      S_FETCH1,
      S_FETCH2,
      S_FETCH3,
      S_FETCH4,
      S_DECODE,
      S_MEMADR,
      S_LBRD,
      S_LBWR,
      S_SBWR,
      S_RTYPEEX,
      S_RTYPEWR,
      S_BEQEX,
      S_JEX,
      S_ADDIEX,
      S_ADDIWR
   } state_e;

   typedef enum logic [1:0] {
      SRCB_B,
      SRCB_IMM,
      SRCB_IMM_SH2
   } srcb_e;

   typedef struct packed {
      logic      memread;
      logic      memwrite;
      logic      iord;
      logic [3:0] irwrite;
      logic      pcinc;
      logic      pcbranch;
      logic      pcjump;
      logic      abwrite;
      logic      srca_a;
      srcb_e     srcb;
      alu_ctrl_e aluctrl;
      logic      aluout_we;
      logic      mdrwrite;
      logic      regwrite;
      logic      regdst_rd;
      logic      memtoreg;
   } ctrl_t;

   // Unknown functs map to ALU_ZERO so the R-type writes 0 to rd.
   function automatic alu_ctrl_e alu_decode(input logic [5:0] funct);
      alu_ctrl_e r;
      case (funct)
         FN_ADD:  r = ALU_ADD;
         FN_SUB:  r = ALU_SUB;
         FN_AND:  r = ALU_AND;
         FN_OR:   r = ALU_OR;
         FN_SLT:  r = ALU_SLT;
         default: r = ALU_ZERO;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mips_controller.sv
// Multicycle FSM and ALU decode. Control word is registered alongside the state
// by decoding the next state, so every datapath control is a flop output.
module mips_controller
   import mips_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output ctrl_t      ctrl_o
);

   state_e state_q, state_d;
   ctrl_t  ctrl_q;

   function automatic ctrl_t ctrl_for(input state_e s, input logic [5:0] funct);
      ctrl_t c;
      c = '0;
      c.srcb    = SRCB_B;
      c.aluctrl = ALU_ADD;
      case (s)
         S_FETCH1: begin c.memread = 1'b1; c.irwrite = 4'b0001; c.pcinc = 1'b1; end
         S_FETCH2: begin c.memread = 1'b1; c.irwrite = 4'b0010; c.pcinc = 1'b1; end
         S_FETCH3: begin c.memread = 1'b1; c.irwrite = 4'b0100; c.pcinc = 1'b1; end
         S_FETCH4: begin c.memread = 1'b1; c.irwrite = 4'b1000; c.pcinc = 1'b1; end
         S_DECODE: begin
            c.abwrite   = 1'b1;
            c.srcb      = SRCB_IMM_SH2;
            c.aluout_we = 1'b1;
         end
         S_MEMADR, S_ADDIEX: begin
            c.srca_a    = 1'b1;
            c.srcb      = SRCB_IMM;
            c.aluout_we = 1'b1;
         end
         S_LBRD:    begin c.memread = 1'b1; c.iord = 1'b1; c.mdrwrite = 1'b1; end
         S_LBWR:    begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
         S_SBWR:    begin c.memwrite = 1'b1; c.iord = 1'b1; end
         S_RTYPEEX: begin
            c.srca_a    = 1'b1;
            c.aluctrl   = alu_decode(funct);
            c.aluout_we = 1'b1;
         end
         S_RTYPEWR: begin c.regwrite = 1'b1; c.regdst_rd = 1'b1; end
         S_BEQEX:   begin c.srca_a = 1'b1; c.aluctrl = ALU_SUB; c.pcbranch = 1'b1; end
         S_JEX:     c.pcjump = 1'b1;
         S_ADDIWR:  c.regwrite = 1'b1;
         default:   ;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = S_FETCH1;
      case (state_q)
         S_FETCH1: state_d = S_FETCH2;
         S_FETCH2: state_d = S_FETCH3;
         S_FETCH3: state_d = S_FETCH4;
         S_FETCH4: state_d = S_DECODE;
         S_DECODE: begin
            case (op_i)
               OP_LB, OP_SB: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_J:         state_d = S_JEX;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_FETCH1;
            endcase
         end
         S_MEMADR:  state_d = (op_i == OP_LB) ? S_LBRD : S_SBWR;
         S_LBRD:    state_d = S_LBWR;
         S_RTYPEEX: state_d = S_RTYPEWR;
         S_ADDIEX:  state_d = S_ADDIWR;
         default:   state_d = S_FETCH1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_FETCH1;
         ctrl_q  <= ctrl_for(S_FETCH1, funct_i);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_for(state_d, funct_i);
      end
   end

   assign ctrl_o = ctrl_q;

endmodule

// File: rtl/mips.sv
// Multicycle 8-bit MIPS-subset core: datapath (PC, IR, register file, ALU and
// operand muxes) around mips_controller; sole master of a byte-wide memory.
module mips
   import mips_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int REGBITS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] memdata,
   output logic             memread,
   output logic             memwrite,
   output logic [WIDTH-1:0] adr,
   output logic [WIDTH-1:0] writedata
);

   localparam int NREGS = 2 ** REGBITS;

   ctrl_t ctrl;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [31:0]      ir_q, ir_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] aluout_q, aluout_d;
   logic [WIDTH-1:0] mdr_q, mdr_d;
   logic [WIDTH-1:0] rf_q [NREGS];

   logic [5:0]         op, funct;
   logic [REGBITS-1:0] rs, rt, rd, wa;
   logic [WIDTH-1:0]   imm, rd1, rd2, wd;
   logic [WIDTH-1:0]   srca, srcb, aluresult;
   logic               zero;
   logic               unused_ir;

   mips_controller u_ctrl (
      .clk_i   (clk),
      .rst_ni  (reset),
      .op_i    (op),
      .funct_i (funct),
      .ctrl_o  (ctrl)
   );

   function automatic logic [WIDTH-1:0] alu(input alu_ctrl_e c,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] diff;
      logic [WIDTH-1:0] r;
      diff = x - y;
      case (c)
         ALU_ADD: r = x + y;
         ALU_SUB: r = diff;
         ALU_AND: r = x & y;
         ALU_OR:  r = x | y;
         ALU_SLT: r = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
         default: r = '0;
      endcase
      return r;
   endfunction

   assign op    = ir_q[31:26];
   assign funct = ir_q[5:0];
   assign rs    = ir_q[21 +: REGBITS];
   assign rt    = ir_q[16 +: REGBITS];
   assign rd    = ir_q[11 +: REGBITS];
   assign imm   = ir_q[WIDTH-1:0];
   assign unused_ir = ^{ir_q[25:24], ir_q[20:19], ir_q[15:14], ir_q[10:8]};

   assign rd1 = (rs == '0) ? '0 : rf_q[rs];
   assign rd2 = (rt == '0) ? '0 : rf_q[rt];

   always_comb begin
      srca = ctrl.srca_a ? a_q : pc_q;
      case (ctrl.srcb)
         SRCB_IMM:     srcb = imm;
         SRCB_IMM_SH2: srcb = {imm[WIDTH-3:0], 2'b00};
         default:      srcb = b_q;
      endcase
   end

   assign aluresult = alu(ctrl.aluctrl, srca, srcb);
   assign zero      = (aluresult == '0);

   assign wa = ctrl.regdst_rd ? rd : rt;
   assign wd = ctrl.memtoreg ? mdr_q : aluout_q;

   always_comb begin
      pc_d = pc_q;
      if (ctrl.pcinc)
         pc_d = pc_q + WIDTH'(1);
      else if (ctrl.pcbranch && zero)
         pc_d = aluout_q;
      else if (ctrl.pcjump)
         pc_d = {ir_q[WIDTH-3:0], 2'b00};

      // Instruction bytes arrive most-significant first.
      ir_d = ir_q;
      for (int i = 0; i < 4; i++)
         if (ctrl.irwrite[i])
            ir_d[31-8*i -: 8] = memdata[7:0];

      a_d      = ctrl.abwrite   ? rd1       : a_q;
      b_d      = ctrl.abwrite   ? rd2       : b_q;
      aluout_d = ctrl.aluout_we ? aluresult : aluout_q;
      mdr_d    = ctrl.mdrwrite  ? memdata   : mdr_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
         mdr_q    <= '0;
         for (int i = 0; i < NREGS; i++)
            rf_q[i] <= '0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluout_q <= aluout_d;
         mdr_q    <= mdr_d;
         if (ctrl.regwrite && (wa != '0))
            rf_q[wa] <= wd;
      end
   end

   // Reset forces the bus idle immediately, so a store in flight never lands.
   assign memread   = ctrl.memread | ~reset;
   assign memwrite  = ctrl.memwrite & reset;
   assign adr       = !reset ? '0 : (ctrl.iord ? aluout_q : pc_q);
   assign writedata = !reset ? '0 : b_q;

endmodule

// File: tb/tb_mips.sv
// Directed-program bench for the mips core: expected stores go into a
// scoreboard queue and a monitor compares every memwrite cycle against it.
module tb_mips;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] memdata, adr, writedata;
   logic       memread, memwrite;

   logic [7:0] mem [256];
   logic [7:0] pa;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int first_wr;

   mips #(.WIDTH(8), .REGBITS(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .memdata   (memdata),
      .memread   (memread),
      .memwrite  (memwrite),
      .adr       (adr),
      .writedata (writedata)
   );

   always #5 clk = ~clk;
   assign memdata = mem[adr];

   function automatic logic [31:0] i_addi(input int rt, input int rs, input int imm);
      return {6'b001000, 5'(rs), 5'(rt), 8'h00, 8'(imm)};
   endfunction
   function automatic logic [31:0] i_sb(input int rt, input int rs, input int imm);
      return {6'b101000, 5'(rs), 5'(rt), 8'h00, 8'(imm)};
   endfunction
   function automatic logic [31:0] i_lb(input int rt, input int rs, input int imm);
      return {6'b100000, 5'(rs), 5'(rt), 8'h00, 8'(imm)};
   endfunction
   function automatic logic [31:0] i_beq(input int rs, input int rt, input int imm);
      return {6'b000100, 5'(rs), 5'(rt), 8'h00, 8'(imm)};
   endfunction
   function automatic logic [31:0] i_r(input int rd, input int rs, input int rt, input int fn);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, 6'(fn)};
   endfunction
   function automatic logic [31:0] i_j(input int target);
      return {6'b000010, 26'(target >> 2)};
   endfunction

   task automatic clear_mem();
      foreach (mem[i]) mem[i] = 8'h00;
      pa = 8'h00;
   endtask

   task automatic put(input logic [31:0] w);
      mem[pa]         = w[31:24];
      mem[pa + 8'd1]  = w[23:16];
      mem[pa + 8'd2]  = w[15:8];
      mem[pa + 8'd3]  = w[7:0];
      pa = pa + 8'd4;
   endtask

   task automatic expect_store(input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      next_cycle();
      check({tag, "_rst_adr"}, 32'(adr), 32'h00);
      check({tag, "_rst_memread"}, 32'(memread), 32'h1);
      check({tag, "_rst_memwrite"}, 32'(memwrite), 32'h0);
      check({tag, "_rst_writedata"}, 32'(writedata), 32'h00);
   endtask

   task automatic release_rst();
      reset = 1'b1;
      #1;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         next_cycle();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d stores still pending after %0d cycles, expected 0", name, sb.size(), budget);
      end
   endtask

   // Scoreboard monitor: every write cycle must match the next queued store.
   always @(negedge clk) begin
      exp_t e;
      if (reset && memwrite) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_store: adr=%0h data=%0h, expected no store", adr, writedata);
         end else begin
            e = sb.pop_front();
            if (adr !== e.a || writedata !== e.d) begin
               errors++;
               $display("FAIL store: adr=%0h data=%0h, expected adr=%0h data=%0h",
                        adr, writedata, e.a, e.d);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Program 1: ADDI/SB, store timing, fetch addresses, jump to 0x10.
      clear_mem();
      put(i_addi(1, 0, 5));
      put(i_sb(1, 0, 255));
      put(i_j(16));
      put(i_sb(0, 0, 255));
      put(i_addi(1, 1, 1));
      put(i_sb(1, 0, 255));
      put(i_j(24));
      expect_store(8'hFF, 8'h05);
      expect_store(8'hFF, 8'h06);
      do_reset("p1");
      release_rst();
      first_wr = -1;
      for (int k = 0; k < 30; k++) begin
         if (k < 4) begin
            check($sformatf("fetch%0d_adr", k), 32'(adr), 32'(k));
            check($sformatf("fetch%0d_memread", k), 32'(memread), 32'h1);
         end
         if (memwrite && first_wr < 0) first_wr = k;
         next_cycle();
      end
      check("sb_write_cycle", 32'(first_wr), 32'd13);
      wait_drain(500, "p1_drain");

      // Program 2: R-type ALU ops, undefined funct, BEQ taken / not taken.
      clear_mem();
      put(i_addi(2, 0, 7));
      put(i_addi(3, 0, 3));
      put(i_r(4, 2, 3, 6'b100000)); put(i_sb(4, 0, 255));
      put(i_r(4, 2, 3, 6'b100010)); put(i_sb(4, 0, 255));
      put(i_r(4, 2, 3, 6'b100100)); put(i_sb(4, 0, 255));
      put(i_r(4, 2, 3, 6'b100101)); put(i_sb(4, 0, 255));
      put(i_r(4, 3, 2, 6'b101010)); put(i_sb(4, 0, 255));
      put(i_r(4, 2, 3, 6'b101010)); put(i_sb(4, 0, 255));
      put(i_addi(4, 0, 9));
      put(i_r(4, 2, 3, 6'b000111)); put(i_sb(4, 0, 255));
      put(i_beq(2, 2, 1));
      put(i_sb(2, 0, 255));
      put(i_beq(2, 3, 1));
      put(i_sb(3, 0, 255));
      put(i_j(84));
      expect_store(8'hFF, 8'd10);
      expect_store(8'hFF, 8'd4);
      expect_store(8'hFF, 8'd3);
      expect_store(8'hFF, 8'd7);
      expect_store(8'hFF, 8'd1);
      expect_store(8'hFF, 8'd0);
      expect_store(8'hFF, 8'd0);
      expect_store(8'hFF, 8'd3);
      do_reset("p2");
      release_rst();
      wait_drain(3000, "p2_drain");
      repeat (40) next_cycle();

      // Program 3: LB from 0x40 then store it back.
      clear_mem();
      put(i_lb(4, 0, 8'h40));
      put(i_sb(4, 0, 255));
      put(i_j(8));
      mem[8'h40] = 8'h2A;
      expect_store(8'hFF, 8'h2A);
      do_reset("p3");
      release_rst();
      for (int k = 0; k < 8; k++) begin
         if (k == 6) begin
            check("lbrd_adr", 32'(adr), 32'h40);
            check("lbrd_memread", 32'(memread), 32'h1);
            check("lbrd_memwrite", 32'(memwrite), 32'h0);
         end
         next_cycle();
      end
      wait_drain(500, "p3_drain");
      repeat (40) next_cycle();

      // Program 4: Fibonacci until 13, then mid-run reset and rerun.
      clear_mem();
      put(i_addi(1, 0, 0));
      put(i_addi(2, 0, 1));
      put(i_addi(3, 0, 13));
      put(i_r(4, 1, 2, 6'b100000));
      put(i_r(1, 2, 0, 6'b100000));
      put(i_r(2, 4, 0, 6'b100000));
      put(i_beq(4, 3, 1));
      put(i_j(12));
      put(i_sb(4, 0, 255));
      put(i_j(36));
      expect_store(8'hFF, 8'd13);
      do_reset("fib1");
      release_rst();
      wait_drain(2000, "fib1_drain");
      repeat (40) next_cycle();

      do_reset("fib2");
      release_rst();
      repeat (100) next_cycle();
      do_reset("fib_mid");
      expect_store(8'hFF, 8'd13);
      release_rst();
      check("fib_restart_adr", 32'(adr), 32'h00);
      wait_drain(2000, "fib2_drain");
      repeat (40) next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
